rect_fill: RTL and testbench
============================

Name: rect_fill

Overview:
Parametrised successor to the full-screen fill block. It plots an axis-aligned rectangle, given by two corner points in any order, into the VGA adapter at one pixel per clock. Corners beyond the screen are clipped. Four colour modes are supported: solid, column stripes, row stripes and checkerboard. It uses the same start/done handshake as the fill block and sits between the top-level controller and the VGA adapter's plot port.

Parameters:
SCREEN_W, 160, visible columns; valid x is 0..SCREEN_W-1
SCREEN_H, 120, visible rows; valid y is 0..SCREEN_H-1
X_W, 8, width of x coordinates; must satisfy 2^X_W >= SCREEN_W
Y_W, 7, width of y coordinates; must satisfy 2^Y_W >= SCREEN_H
COLOUR_W, 3, colour width

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
x0, x1  in  X_W  corner x coordinates, any order, inclusive
y0, y1  in  Y_W  corner y coordinates, any order, inclusive
colour  in  COLOUR_W  base colour
mode  in  2  00 solid, 01 column stripe, 10 row stripe, 11 checker
busy  out  1  high in SETUP and FILL
done  out  1  completion flag (see handshake)
vga_x  out  X_W  pixel x to adapter
vga_y  out  Y_W  pixel y to adapter
vga_colour  out  COLOUR_W  pixel colour to adapter
vga_plot  out  1  write strobe to adapter

Behaviour:
- States: IDLE, SETUP, FILL, DONE. All outputs are registered.
- Reset: state goes to IDLE; busy, done, vga_x, vga_y, vga_colour and vga_plot all go to 0. Reset takes priority in every state, so asserting it mid-FILL aborts the fill: vga_plot is 0 from the next cycle and no further pixels are plotted.
- IDLE: when start=1 is sampled, latch x0, x1, y0, y1, colour and mode, then go to SETUP. Input changes after this edge are ignored until the next request.
- SETUP (exactly 1 cycle):
  - xl = min(x0,x1), xh = min(max(x0,x1), SCREEN_W-1).
  - yl and yh are derived the same way against SCREEN_H-1.
  - If xl > SCREEN_W-1 or yl > SCREEN_H-1, the rectangle is empty: go to DONE with no plots.
  - Otherwise set cursor (x,y) = (xl,yl) and go to FILL.
- FILL:
  - Each cycle drives vga_plot=1 with the current cursor on vga_x/vga_y.
  - Scan is column-major: y increments first; when y=yh, y returns to yl and x increments.
  - After pixel (xh,yh), go to DONE.
  - Pixel count is N = (xh-xl+1)*(yh-yl+1). vga_plot is high for exactly N consecutive cycles.
- Colour per pixel:
  - mode 00: colour.
  - mode 01: x mod 2^COLOUR_W.
  - mode 10: y mod 2^COLOUR_W.
  - mode 11: colour when x[0]^y[0]=0, otherwise ~colour.
- Latency:
  - start is sampled at edge k.
  - busy=1 from k+1.
  - First plot is visible after edge k+2.
  - done=1 and vga_plot=0 after edge k+N+2.
  - For an empty rectangle, done=1 after edge k+2.
- DONE:
  - done=1, vga_plot=0, busy=0.
  - vga_x and vga_y hold the last plotted pixel; for an empty rectangle they hold their previous values.
  - Stay in DONE while start=1; holding start high never retriggers a fill.
  - When start=0 is sampled, go to IDLE; done=0 from the next cycle.
  - A new request therefore needs start low for at least one sampled cycle.
- Arithmetic: comparisons and clipping use X_W/Y_W-bit unsigned values, with no wrap-around. The cursor never exceeds xh/yh, so no overflow occurs even at x=2^X_W-1.
- Single-pixel rectangle (x0=x1, y0=y1 inside the screen): N=1, one plot.

Test Plan:
1. Full screen: (0,0)-(159,119), mode 01.
   -> 19200 plots, first (0,0) with colour 0, last (159,119) with colour 7.
   -> done=1 exactly 19202 cycles after the start sample.
   -> In DONE: vga_x=159, vga_y=119, vga_plot=0.
2. Swapped corners: (10,5)-(3,2), mode 00, colour 3'b101.
   -> 32 plots, sequence (3,2),(3,3),(3,4),(3,5),(4,2)...(10,5), all colour 5.
3. Clipping: (150,110)-(200,127).
   -> 100 plots, last pixel (159,119).
   Empty: (170,0)-(180,5).
   -> 0 plots, done=1 two cycles after the start sample.
4. Handshake: hold start=1 for 50 cycles after done.
   -> done stays 1, no plots.
   Drop start to 0.
   -> done=0 one cycle later; a new pulse starts a fresh fill.
5. Reset mid-fill: assert rst after pixel 100 of test 1.
   -> Next cycle all outputs are 0 and state is IDLE.
   A subsequent single-pixel request (7,7), mode 11, colour 3'b010.
   -> Exactly one plot at (7,7), colour 3'b010.
6. Checker: (0,0)-(1,1), mode 11, colour 3'b001.
   -> Colours 1,6,6,1 in scan order.

Source files
------------

// File: rtl/rect_fill.sv
// rtl/rect_fill.sv - plots a clipped, patterned axis-aligned rectangle into the VGA adapter, one pixel per clock
module rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y0,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t                state;
    logic [X_W-1:0]        rx0, rx1, xh, cx;
    logic [Y_W-1:0]        ry0, ry1, yl, yh, cy;
    logic [COLOUR_W-1:0]   rcol;
    logic [1:0]            rmode;

    logic [X_W-1:0]        lo_x, hi_x, clip_x;
    logic [Y_W-1:0]        lo_y, hi_y, clip_y;
    logic                  empty;
    logic [COLOUR_W-1:0]   pix_colour;
    logic [X_W+COLOUR_W-1:0] x_ext;
    logic [Y_W+COLOUR_W-1:0] y_ext;

    always_comb begin
        lo_x   = (rx0 < rx1) ? rx0 : rx1;
        hi_x   = (rx0 < rx1) ? rx1 : rx0;
        clip_x = (hi_x > X_MAX) ? X_MAX : hi_x;
        lo_y   = (ry0 < ry1) ? ry0 : ry1;
        hi_y   = (ry0 < ry1) ? ry1 : ry0;
        clip_y = (hi_y > Y_MAX) ? Y_MAX : hi_y;
        empty  = (lo_x > X_MAX) || (lo_y > Y_MAX);
    end

    // Zero-extension lets the stripe modes take "mod 2^COLOUR_W" even when a coordinate is narrower than the colour.
    always_comb begin
        x_ext = {{COLOUR_W{1'b0}}, cx};
        y_ext = {{COLOUR_W{1'b0}}, cy};
        case (rmode)
            2'b00:   pix_colour = rcol;
            2'b01:   pix_colour = x_ext[COLOUR_W-1:0];
            2'b10:   pix_colour = y_ext[COLOUR_W-1:0];
            default: pix_colour = (cx[0] ^ cy[0]) ? ~rcol : rcol;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            rx0        <= '0;
            rx1        <= '0;
            ry0        <= '0;
            ry1        <= '0;
            rcol       <= '0;
            rmode      <= '0;
            xh         <= '0;
            yl         <= '0;
            yh         <= '0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (start) begin
                        rx0   <= x0;
                        rx1   <= x1;
                        ry0   <= y0;
                        ry1   <= y1;
                        rcol  <= colour;
                        rmode <= mode;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    xh    <= clip_x;
                    yl    <= lo_y;
                    yh    <= clip_y;
                    cx    <= lo_x;
                    cy    <= lo_y;
                    state <= empty ? DONE : FILL;
                end
                FILL: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= pix_colour;
                    vga_plot   <= 1'b1;
                    // Column-major scan; the cursor stops at (xh,yh) so it never wraps.
                    if (cy == yh) begin
                        cy <= yl;
                        if (cx == xh) begin
                            state <= DONE;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end else begin
                        cy <= cy + 1'b1;
                    end
                end
                DONE: begin
                    vga_plot <= 1'b0;
                    // First DONE cycle raises done; afterwards wait for start to be released.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// tb/tb_rect_fill.sv - directed self-checking bench for rect_fill
module tb_rect_fill;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] colour = '0;
    logic [1:0] mode = '0;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int px[$], py[$], pcol[$], pcyc[$];

    rect_fill dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .colour(colour), .mode(mode),
        .busy(busy), .done(done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vga_plot) begin
            px.push_back(int'(vga_x));
            py.push_back(int'(vga_y));
            pcol.push_back(int'(vga_colour));
            pcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        px.delete(); py.delete(); pcol.delete(); pcyc.delete();
    endtask

    // Issues a request and leaves start high; lat is done latency from the start sample, -1 on timeout.
    task automatic run_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int md, output int lat);
        int k;
        @(negedge clk);
        clear_log();
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        colour = 3'(col); mode = 2'(md);
        start = 1'b1;
        k = cyc + 1;
        lat = -1;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - k;
                break;
            end
        end
    endtask

    task automatic drop_start(input string tag);
        start = 1'b0;
        @(negedge clk);
        check(tag, int'(done), 0);
    endtask

    int lat, n, held_done, cnt_before;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_xy", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
        rst = 1'b0;

        // Full screen, column stripes
        run_rect(0, 0, 159, 119, 0, 1, lat);
        check("full_lat", lat, 19202);
        check("full_count", px.size(), 19200);
        if (px.size() == 19200) begin
            check("full_first", px[0] * 1000 + py[0] * 10 + pcol[0], 0);
            check("full_second_col", px[120] * 1000 + py[120] * 10 + pcol[120], 1001);
            check("full_last", px[19199] * 1000 + py[19199] * 10 + pcol[19199], 159000 + 1190 + 7);
            check("full_contig", pcyc[19199] - pcyc[0] + 1, 19200);
        end
        check("full_done_x", int'(vga_x), 159);
        check("full_done_y", int'(vga_y), 119);
        check("full_done_plot", int'(vga_plot), 0);
        check("full_done_busy", int'(busy), 0);
        drop_start("full_release");

        // Swapped corners, solid
        run_rect(10, 5, 3, 2, 5, 0, lat);
        check("swap_lat", lat, 34);
        check("swap_count", px.size(), 32);
        if (px.size() == 32) begin
            check("swap_p0", px[0] * 100 + py[0], 302);
            check("swap_p1", px[1] * 100 + py[1], 303);
            check("swap_p3", px[3] * 100 + py[3], 305);
            check("swap_p4", px[4] * 100 + py[4], 402);
            check("swap_last", px[31] * 100 + py[31], 1005);
            n = 0;
            foreach (pcol[i]) if (pcol[i] != 5) n++;
            check("swap_colour_bad", n, 0);
        end
        drop_start("swap_release");

        // Clipped to the screen corner
        run_rect(150, 110, 200, 127, 2, 0, lat);
        check("clip_lat", lat, 102);
        check("clip_count", px.size(), 100);
        if (px.size() == 100)
            check("clip_last", px[99] * 1000 + py[99], 159119);
        drop_start("clip_release");

        // Entirely off-screen, then start held high in DONE
        run_rect(170, 0, 180, 5, 1, 0, lat);
        check("empty_lat", lat, 2);
        check("empty_count", px.size(), 0);
        check("empty_hold_x", int'(vga_x), 159);
        held_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) held_done++;
        end
        check("hold_done", held_done, 50);
        check("hold_plots", px.size(), 0);
        drop_start("hold_release");

        // Fresh request after release
        run_rect(2, 2, 2, 3, 4, 0, lat);
        check("fresh_count", px.size(), 2);
        check("fresh_lat", lat, 4);
        drop_start("fresh_release");

        // Reset mid-fill
        @(negedge clk);
        clear_log();
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd159; y1 = 7'd119; colour = 3'd0; mode = 2'b01;
        start = 1'b1;
        for (int i = 0; i < 200 && px.size() <= 100; i++) @(negedge clk);
        check("abort_reached", int'(px.size() > 100), 1);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("abort_plot", int'(vga_plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
        rst = 1'b0;
        cnt_before = px.size();
        repeat (5) @(negedge clk);
        check("abort_no_plots", px.size() - cnt_before, 0);

        // Single pixel, checker with x0^y0=0
        run_rect(7, 7, 7, 7, 2, 3, lat);
        check("single_lat", lat, 3);
        check("single_count", px.size(), 1);
        if (px.size() == 1)
            check("single_pix", px[0] * 1000 + py[0] * 10 + pcol[0], 7072);
        drop_start("single_release");

        // Checkerboard 2x2
        run_rect(0, 0, 1, 1, 1, 3, lat);
        check("chk_count", px.size(), 4);
        if (px.size() == 4)
            check("chk_colours", pcol[0] * 1000 + pcol[1] * 100 + pcol[2] * 10 + pcol[3], 1661);
        drop_start("chk_release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
